mux_rr_nto1: RTL

- Parametrised N-to-1 registered multiplexer with valid/ready handshakes on every input channel and on the output.
- Two selection modes: fixed select, where a `sel` port picks the channel, and round-robin arbitration across all valid channels.
- Single-entry output register gives one-cycle latency and full throughput.
- Used wherever several streams merge onto one downstream consumer. Successor to the combinational 4:1 mux.

---
 rtl/mux_rr_nto1.sv | 97 +++++++++
 1 files changed

// File: rtl/mux_rr_nto1.sv
// mux_rr_nto1: N-to-1 registered stream multiplexer.
// Selection is either by a fixed `sel` index or by round-robin arbitration
// over all valid channels. A single output register gives one-cycle latency
// and sustains one word per cycle when downstream keeps out_ready high.
module mux_rr_nto1 #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0] out_data_r;
  logic [SEL_W-1:0] out_chan_r;
  logic             out_valid_r;
  logic [SEL_W-1:0] rr_ptr_r;

  logic             load_en_s;
  logic             found_s;
  logic [SEL_W-1:0] gnt_idx_s;
  logic             xfer_s;
  logic [WIDTH-1:0] gnt_data_s;
  logic [SEL_W-1:0] rr_next_s;
  int               cand_s;

  // Pick the granted channel: fixed index in mode 0, rotating priority from rr_ptr in mode 1.
  always_comb begin
    found_s   = 1'b0;
    gnt_idx_s = {SEL_W{1'b0}};
    cand_s    = 0;
    if (mode == 1'b0) begin
      // Out-of-range sel (non-power-of-2 channel count) grants nobody.
      if (int'(sel) < CHANNELS) begin
        found_s   = in_valid[sel];
        gnt_idx_s = sel;
      end else begin
        found_s   = 1'b0;
        gnt_idx_s = {SEL_W{1'b0}};
      end
    end else begin
      // Walk offsets from furthest to nearest so the nearest valid channel wins.
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        cand_s    = int'(rr_ptr_r) + k;
        cand_s    = (cand_s >= CHANNELS) ? (cand_s - CHANNELS) : cand_s;
        gnt_idx_s = in_valid[cand_s] ? SEL_W'(cand_s) : gnt_idx_s;
        found_s   = found_s | in_valid[cand_s];
      end
    end
  end

  // Handshake qualification, per-channel ready, data selection and next pointer.
  always_comb begin
    load_en_s  = ~out_valid_r | out_ready;
    xfer_s     = load_en_s & found_s & ~rst;
    in_ready   = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = xfer_s & (int'(gnt_idx_s) == i);
    end
    gnt_data_s = in_data[int'(gnt_idx_s)*WIDTH +: WIDTH];
    rr_next_s  = (gnt_idx_s == SEL_W'(CHANNELS - 1)) ? {SEL_W{1'b0}}
                                                       : (gnt_idx_s + SEL_W'(1));
  end

  // Output register and round-robin pointer; a load may replace a word being drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_r  <= {WIDTH{1'b0}};
      out_chan_r  <= {SEL_W{1'b0}};
      out_valid_r <= 1'b0;
      rr_ptr_r    <= {SEL_W{1'b0}};
    end else if (xfer_s) begin
      out_data_r  <= gnt_data_s;
      out_chan_r  <= gnt_idx_s;
      out_valid_r <= 1'b1;
      rr_ptr_r    <= mode ? rr_next_s : rr_ptr_r;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_data  = out_data_r;
  assign out_chan  = out_chan_r;
  assign out_valid = out_valid_r;

endmodule
